// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver
// Command-driven S/R pulse generator for a bank of SR flip-flops. Commands
// ({op, idx}) arrive over a valid/ready handshake and queue in a small FIFO.
// They execute one at a time: a registered S or R pulse of fixed width, then a
// bounded wait for the flip-flop's Q to confirm. The result is reported as a
// one-cycle done or err pulse. S and R are never high together, and at most
// one line of the bank is driven at any time.

module sr_pulse_driver #(
   parameter int N            = 8,
   parameter int PULSE_CYCLES = 2,
   parameter int TIMEOUT      = 15,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_op,
   input  logic [$clog2(N)-1:0] cmd_idx,
   output logic [N-1:0]         S,
   output logic [N-1:0]         R,
   input  logic [N-1:0]         Q,
   output logic                 done,
   output logic                 err,
   output logic                 busy
);

   localparam int IDX_W   = $clog2(N);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int PCNT_W  = $clog2(PULSE_CYCLES + 1);
   localparam int TCNT_W  = $clog2(TIMEOUT + 1);
   localparam int ENTRY_W = IDX_W + 1;

   // Upper bound for a legal index. It is one bit wider than the index so
   // that N can be represented even when N is a power of two.
   localparam logic [IDX_W:0]  N_LIMIT    = (IDX_W + 1)'(N);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_CYCLES - 1);
   localparam logic [TCNT_W-1:0] TOUT_LAST  = TCNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      CHECK = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head_entry;
   logic               head_op;
   logic [IDX_W-1:0]   head_idx;
   logic               head_idx_ok;
   logic [N-1:0]       head_onehot;

   // ------------------------------------------------------------------
   // Controller state
   // ------------------------------------------------------------------
   state_t             state_q, state_d;
   logic               op_q, op_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N-1:0]       s_q, s_d;
   logic [N-1:0]       r_q, r_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [PCNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
   logic [TCNT_W-1:0]  tout_cnt_q, tout_cnt_d;

   logic [N-1:0]       q_shift;
   logic               q_sel;

   // ready is a pure function of the stored count, so it never depends
   // combinationally on cmd_valid
   assign fifo_full  = (count_q == FULL_COUNT);
   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state_q == IDLE) && !fifo_empty;

   assign head_entry  = fifo_mem_q[rd_ptr_q];
   assign head_op     = head_entry[IDX_W];
   assign head_idx    = head_entry[IDX_W-1:0];
   assign head_idx_ok = ({1'b0, head_idx} < N_LIMIT);
   assign head_onehot = {{(N-1){1'b0}}, 1'b1} << head_idx;

   // Readback bit of the flip-flop the current command is addressing
   assign q_shift = Q >> idx_q;
   assign q_sel   = q_shift[0];

   // Advance the FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // FIFO storage is not reset; only the pointers and count define which entries are live
   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {cmd_op, cmd_idx};
      end
   end

   // FIFO pointer and occupancy registers
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Next-state logic: pop and launch a pulse, time the pulse, then wait for Q to confirm or time out
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      idx_d       = idx_q;
      s_d         = s_q;
      r_d         = r_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      pulse_cnt_d = pulse_cnt_q;
      tout_cnt_d  = tout_cnt_q;

      unique case (state_q)
         IDLE: begin
            s_d = '0;
            r_d = '0;
            if (pop) begin
               op_d  = head_op;
               idx_d = head_idx;
               if (head_idx_ok) begin
                  state_d     = PULSE;
                  pulse_cnt_d = '0;
                  if (head_op) begin
                     s_d = head_onehot;
                  end else begin
                     r_d = head_onehot;
                  end
               end else begin
                  // An out-of-range index is rejected without touching the bank
                  err_d = 1'b1;
               end
            end
         end

         PULSE: begin
            if (pulse_cnt_q == PULSE_LAST) begin
               s_d        = '0;
               r_d        = '0;
               tout_cnt_d = '0;
               state_d    = CHECK;
            end else begin
               pulse_cnt_d = pulse_cnt_q + PCNT_W'(1);
            end
         end

         CHECK: begin
            s_d = '0;
            r_d = '0;
            if (q_sel == op_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (tout_cnt_q == TOUT_LAST) begin
               err_d      = 1'b1;
               tout_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               tout_cnt_d = tout_cnt_q + TCNT_W'(1);
            end
         end

         default: begin
            s_d     = '0;
            r_d     = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Controller registers; reset drops any active S/R line immediately and discards the command in flight
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= IDLE;
         op_q        <= 1'b0;
         idx_q       <= '0;
         s_q         <= '0;
         r_q         <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         pulse_cnt_q <= '0;
         tout_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         s_q         <= s_d;
         r_q         <= r_d;
         done_q      <= done_d;
         err_q       <= err_d;
         pulse_cnt_q <= pulse_cnt_d;
         tout_cnt_q  <= tout_cnt_d;
      end
   end

   assign S    = s_q;
   assign R    = r_q;
   assign done = done_q;
   assign err  = err_q;
   assign busy = (state_q != IDLE) || !fifo_empty;

   // Safety properties of the bank drive and of the status pulses
   a_no_sr_overlap: assert property (@(posedge Clk) disable iff (Rst) ((s_q & r_q) == '0));
   a_single_line:   assert property (@(posedge Clk) disable iff (Rst) $onehot0(s_q | r_q));
   a_done_xor_err:  assert property (@(posedge Clk) disable iff (Rst) !(done_q && err_q));

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver
// Self-checking bench for sr_pulse_driver. A queue-based reference model
// predicts every cycle's S/R/done/err/busy/cmd_ready from the command
// sequence. Scenario tasks add targeted timing checks. A second instance with
// N=6 exercises rejection of an out-of-range index.

module tb_sr_pulse_driver;

   localparam int N     = 8;
   localparam int N6    = 6;
   localparam int PC    = 2;
   localparam int TO    = 15;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic       op;
      logic [2:0] idx;
   } cmd_t;

   logic         Clk;
   logic         Rst;

   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_op;
   logic [2:0]   cmd_idx;
   logic [N-1:0] S;
   logic [N-1:0] R;
   logic [N-1:0] Q;
   logic         done;
   logic         err;
   logic         busy;

   logic          cmd_valid6;
   logic          cmd_ready6;
   logic          cmd_op6;
   logic [2:0]    cmd_idx6;
   logic [N6-1:0] S6;
   logic [N6-1:0] R6;
   logic [N6-1:0] Q6;
   logic          done6;
   logic          err6;
   logic          busy6;

   logic [N-1:0]  ff_q;
   logic [N6-1:0] ff6_q;
   logic          tie_en;
   logic [N-1:0]  tie_val;

   int checks;
   int errors;

   // reference model state
   cmd_t mq[$];
   bit   m_active;
   bit   m_op;
   int   m_idx;
   int   m_age;
   bit   m_done;
   bit   m_err;

   // observation log
   cmd_t         pulse_log[$];
   int           done_count;
   int           err_count;
   bit [N-1:0]   prev_line;

   sr_pulse_driver #(.N(N), .PULSE_CYCLES(PC), .TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut (
      .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_idx(cmd_idx), .S(S), .R(R), .Q(Q),
      .done(done), .err(err), .busy(busy)
   );

   sr_pulse_driver #(.N(N6), .PULSE_CYCLES(PC), .TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut6 (
      .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid6), .cmd_ready(cmd_ready6),
      .cmd_op(cmd_op6), .cmd_idx(cmd_idx6), .S(S6), .R(R6), .Q(Q6),
      .done(done6), .err(err6), .busy(busy6)
   );

   assign Q  = tie_en ? tie_val : ff_q;
   assign Q6 = ff6_q;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // SR flip-flop bank behind the main instance
   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ff_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (S[i]) ff_q[i] <= 1'b1;
            else if (R[i]) ff_q[i] <= 1'b0;
         end
      end
   end

   // SR flip-flop bank behind the N=6 instance
   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ff6_q <= '0;
      end else begin
         for (int i = 0; i < N6; i++) begin
            if (S6[i]) ff6_q[i] <= 1'b1;
            else if (R6[i]) ff6_q[i] <= 1'b0;
         end
      end
   end

   // Reference model: command queue plus the age of the active command since its pop
   always @(posedge Clk or posedge Rst) begin
      cmd_t c;
      bit   can_push;
      if (Rst) begin
         mq.delete();
         m_active = 0;
         m_age    = 0;
         m_done   = 0;
         m_err    = 0;
      end else begin
         m_done   = 0;
         m_err    = 0;
         can_push = cmd_valid && (mq.size() < DEPTH);
         if (m_active) begin
            m_age++;
            if (m_age > PC) begin
               if (Q[m_idx] == m_op) begin
                  m_done   = 1;
                  m_active = 0;
               end else if (m_age - PC >= TO) begin
                  m_err    = 1;
                  m_active = 0;
               end
            end
         end else if (mq.size() > 0) begin
            c = mq.pop_front();
            if (int'(c.idx) >= N) begin
               m_err = 1;
            end else begin
               m_active = 1;
               m_age    = 0;
               m_op     = c.op;
               m_idx    = int'(c.idx);
            end
         end
         if (can_push) mq.push_back({cmd_op, cmd_idx});
      end
   end

   // Every cycle: compare against the model, check the S/R safety invariants, log pulses
   always @(negedge Clk) begin
      logic [N-1:0] exp_line;
      logic [N-1:0] exp_s;
      logic [N-1:0] exp_r;
      logic [N-1:0] line;
      cmd_t         c;
      exp_line = (m_active && m_age < PC) ? (N'(1) << m_idx) : '0;
      exp_s    = m_op ? exp_line : '0;
      exp_r    = m_op ? '0 : exp_line;

      checks++;
      if (S !== exp_s) begin
         errors++;
         $display("[TB] FAIL model_S t=%0t got %h expected %h", $time, S, exp_s);
      end
      checks++;
      if (R !== exp_r) begin
         errors++;
         $display("[TB] FAIL model_R t=%0t got %h expected %h", $time, R, exp_r);
      end
      checks++;
      if (done !== m_done) begin
         errors++;
         $display("[TB] FAIL model_done t=%0t got %b expected %b", $time, done, m_done);
      end
      checks++;
      if (err !== m_err) begin
         errors++;
         $display("[TB] FAIL model_err t=%0t got %b expected %b", $time, err, m_err);
      end
      checks++;
      if (busy !== (m_active || mq.size() > 0)) begin
         errors++;
         $display("[TB] FAIL model_busy t=%0t got %b expected %b", $time, busy, (m_active || mq.size() > 0));
      end
      checks++;
      if (cmd_ready !== (mq.size() < DEPTH)) begin
         errors++;
         $display("[TB] FAIL model_ready t=%0t got %b expected %b", $time, cmd_ready, (mq.size() < DEPTH));
      end
      checks++;
      if ((S & R) !== '0 || $countones(S | R) > 1) begin
         errors++;
         $display("[TB] FAIL invariant t=%0t S=%h R=%h required no overlap and at most one line", $time, S, R);
      end
      checks++;
      if ((S6 & R6) !== '0 || $countones(S6 | R6) > 1) begin
         errors++;
         $display("[TB] FAIL invariant6 t=%0t S=%h R=%h required no overlap and at most one line", $time, S6, R6);
      end

      line = S | R;
      if (line != '0 && prev_line == '0) begin
         c.op  = (S != '0);
         c.idx = '0;
         for (int b = 0; b < N; b++) begin
            if (line[b]) c.idx = 3'(b);
         end
         pulse_log.push_back(c);
      end
      prev_line = line;
      if (done) done_count++;
      if (err) err_count++;
   end

   task automatic test_reset;
      Rst = 1'b0;
      #2;
      Rst = 1'b1;
      #1;
      checks++;
      if (S !== '0 || R !== '0) begin
         errors++;
         $display("[TB] FAIL reset_SR got S=%h R=%h expected 0", S, R);
      end
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_status got done=%b err=%b expected 0", done, err);
      end
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_handshake got busy=%b ready=%b expected 0/1", busy, cmd_ready);
      end
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
   endtask

   task automatic test_set_bit3;
      logic [N-1:0] exp_s;
      logic         exp_done;
      @(negedge Clk);
      cmd_valid = 1'b1;
      cmd_op    = 1'b1;
      cmd_idx   = 3'd3;
      for (int j = 0; j <= 7; j++) begin
         @(negedge Clk);
         if (j == 0) cmd_valid = 1'b0;
         exp_s    = (j >= 1 && j <= PC) ? 8'h08 : 8'h00;
         exp_done = (j == PC + 2);
         checks++;
         if (S !== exp_s || R !== '0) begin
            errors++;
            $display("[TB] FAIL set3_lines edge+%0d got S=%h R=%h expected S=%h R=0", j, S, R, exp_s);
         end
         checks++;
         if (done !== exp_done || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL set3_status edge+%0d got done=%b err=%b expected done=%b err=0", j, done, err, exp_done);
         end
      end
   endtask

   task automatic test_fill_order;
      cmd_t cmds [6];
      int   log_start;
      int   done_start;
      int   err_start;
      int   waited;
      bit   r;
      bit   accepted;
      int   t;
      cmds[0] = {1'b1, 3'd4};
      cmds[1] = {1'b1, 3'd0};
      cmds[2] = {1'b0, 3'd0};
      cmds[3] = {1'b1, 3'd7};
      cmds[4] = {1'b0, 3'd7};
      cmds[5] = {1'b1, 3'd1};
      @(negedge Clk);
      #1;
      log_start  = pulse_log.size();
      done_start = done_count;
      err_start  = err_count;
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = cmds[i].op;
         cmd_idx   = cmds[i].idx;
         accepted  = 0;
         waited    = 0;
         while (!accepted && waited < 50) begin
            r = cmd_ready;
            @(negedge Clk);
            waited++;
            accepted = r;
         end
         checks++;
         if (!accepted) begin
            errors++;
            $display("[TB] FAIL fill_accept cmd %0d got not accepted expected accepted within 50 cycles", i);
         end
         if (i == 4) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
               errors++;
               $display("[TB] FAIL fill_full got ready=%b expected 0 after fourth queued push", cmd_ready);
            end
         end
         if (i == 5) begin
            checks++;
            if (waited < 2) begin
               errors++;
               $display("[TB] FAIL fill_stall got %0d cycles expected at least 2", waited);
            end
         end
      end
      cmd_valid = 1'b0;
      t = 0;
      while (busy && t < 200) begin
         @(negedge Clk);
         t++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("[TB] FAIL fill_drain got busy=1 expected idle within 200 cycles");
      end
      @(negedge Clk);
      #1;
      checks++;
      if (pulse_log.size() - log_start != 6) begin
         errors++;
         $display("[TB] FAIL fill_pulses got %0d pulses expected 6", pulse_log.size() - log_start);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (pulse_log[log_start + i] !== cmds[i]) begin
               errors++;
               $display("[TB] FAIL fill_order pulse %0d got %h expected %h", i, pulse_log[log_start + i], cmds[i]);
            end
         end
      end
      checks++;
      if (done_count - done_start != 6 || err_count != err_start) begin
         errors++;
         $display("[TB] FAIL fill_done got done=%0d err=%0d expected 6/0", done_count - done_start, err_count - err_start);
      end
   endtask

   task automatic test_timeout;
      int t;
      int j;
      bit saw_done;
      @(negedge Clk);
      tie_en    = 1'b1;
      tie_val   = '0;
      cmd_valid = 1'b1;
      cmd_op    = 1'b1;
      cmd_idx   = 3'd2;
      @(negedge Clk);
      cmd_valid = 1'b0;
      t = 0;
      while (!S[2] && t < 10) begin
         @(negedge Clk);
         t++;
      end
      checks++;
      if (S !== 8'h04) begin
         errors++;
         $display("[TB] FAIL timeout_pulse got S=%h expected 04", S);
      end
      t = 0;
      while (S[2] && t < 10) begin
         @(negedge Clk);
         t++;
      end
      checks++;
      if (t != PC) begin
         errors++;
         $display("[TB] FAIL timeout_width got %0d cycles expected %0d", t, PC);
      end
      j = 0;
      saw_done = 0;
      while (!err && j < 40) begin
         @(negedge Clk);
         j++;
         if (done) saw_done = 1;
      end
      checks++;
      if (j != TO) begin
         errors++;
         $display("[TB] FAIL timeout_latency got %0d cycles expected %0d", j, TO);
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("[TB] FAIL timeout_done got done=1 expected 0");
      end
      @(negedge Clk);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_errwidth got err=%b expected 0", err);
      end
      tie_en = 1'b0;
   endtask

   task automatic test_invalid_index;
      logic [N6-1:0] exp_s;
      logic          exp_err;
      logic          exp_done;
      @(negedge Clk);
      cmd_valid6 = 1'b1;
      cmd_op6    = 1'b1;
      cmd_idx6   = 3'd7;
      for (int j = 0; j <= 8; j++) begin
         @(negedge Clk);
         if (j == 0) cmd_idx6 = 3'd2;
         if (j == 1) cmd_valid6 = 1'b0;
         exp_s    = (j >= 2 && j < 2 + PC) ? 6'h04 : 6'h00;
         exp_err  = (j == 1);
         exp_done = (j == 3 + PC);
         checks++;
         if (err6 !== exp_err) begin
            errors++;
            $display("[TB] FAIL inv_err edge+%0d got %b expected %b", j, err6, exp_err);
         end
         checks++;
         if (S6 !== exp_s || R6 !== '0) begin
            errors++;
            $display("[TB] FAIL inv_lines edge+%0d got S=%h R=%h expected S=%h R=0", j, S6, R6, exp_s);
         end
         checks++;
         if (done6 !== exp_done) begin
            errors++;
            $display("[TB] FAIL inv_done edge+%0d got %b expected %b", j, done6, exp_done);
         end
      end
   endtask

   task automatic test_reset_mid_pulse;
      @(negedge Clk);
      cmd_valid = 1'b1;
      cmd_op    = 1'b0;
      cmd_idx   = 3'd5;
      @(negedge Clk);
      cmd_op  = 1'b1;
      cmd_idx = 3'd1;
      @(negedge Clk);
      cmd_valid = 1'b0;
      checks++;
      if (R !== 8'h20) begin
         errors++;
         $display("[TB] FAIL rstpulse_pre got R=%h expected 20", R);
      end
      #1;
      Rst = 1'b1;
      #1;
      checks++;
      if (S !== '0 || R !== '0) begin
         errors++;
         $display("[TB] FAIL rstpulse_async got S=%h R=%h expected 0", S, R);
      end
      checks++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rstpulse_status got done=%b err=%b busy=%b ready=%b expected 0/0/0/1", done, err, busy, cmd_ready);
      end
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge Clk);
         checks++;
         if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || (S | R) !== '0) begin
            errors++;
            $display("[TB] FAIL rstpulse_after cycle %0d got done=%b err=%b busy=%b S|R=%h expected all 0", j, done, err, busy, S | R);
         end
      end
   endtask

   task automatic test_random;
      int t;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge Clk);
         if (cyc % 50 == 0) begin
            tie_en  = ($urandom_range(0, 3) == 0);
            tie_val = N'($urandom);
         end
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_op    = 1'($urandom);
         cmd_idx   = 3'($urandom);
      end
      @(negedge Clk);
      cmd_valid = 1'b0;
      tie_en    = 1'b0;
      t = 0;
      while (busy && t < 2000) begin
         @(negedge Clk);
         t++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("[TB] FAIL random_drain got busy=1 expected idle within 2000 cycles");
      end
   endtask

   initial begin
      Rst        = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op     = 1'b0;
      cmd_idx    = '0;
      cmd_valid6 = 1'b0;
      cmd_op6    = 1'b0;
      cmd_idx6   = '0;
      tie_en     = 1'b0;
      tie_val    = '0;
      checks     = 0;
      errors     = 0;
      done_count = 0;
      err_count  = 0;

      test_reset;
      repeat (2) @(negedge Clk);
      test_set_bit3;
      test_fill_order;
      test_timeout;
      test_invalid_index;
      test_reset_mid_pulse;
      test_random;
      repeat (3) @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog got no completion expected finish before 1000000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
